uart_tx_fifo: RTL

- Serial console transmitter that consumes bytes written by the CPU's device port and drives the board `tx` pin.
- Bytes are buffered in a small FIFO and sent as 8N1 frames (start, 8 data bits LSB first, stop) at a rate of one bit per CLOCK_DIV clocks.
- Sits directly downstream of the CPU inside the top-level, on the same divided system clock.
- `tx` routes straight to the board output pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock show-ahead byte FIFO; pop_data always presents the current head.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock_input,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_BITS-1:0]          push_data,
  input  logic                          pop,
  output logic [DATA_BITS-1:0]          pop_data,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;

  // Storage array; only the pointers are reset, which flushes the contents.
  always_ff @(posedge clock_input) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock_input) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clock_input) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push, pop})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_DIV  = 69,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clock_input,
  input  logic                        reset,
  input  logic [7:0]                  write_data,
  input  logic                        write_valid,
  output logic                        write_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int                CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]       BAUD_LAST  = 16'(CLOCK_DIV - 1);
  localparam logic [CW-1:0]     FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [2:0]        LAST_BIT   = 3'(DATA_BITS - 1);

  uart_state_e          state_r;
  logic [15:0]          baud_cnt_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 tx_r;
`ifdef UART_TX_PARITY_EN
  logic                 parity_r;
`endif

  logic [CW-1:0]        count_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 baud_tc_s;
  logic                 nonempty_s;

  assign write_ready = (count_s != FULL_COUNT);
  assign push_s      = write_valid & write_ready;
  assign nonempty_s  = (count_s != {CW{1'b0}});
  assign baud_tc_s   = (baud_cnt_r == BAUD_LAST);

  uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_input (clock_input),
    .reset       (reset),
    .push        (push_s),
    .push_data   (write_data),
    .pop         (pop_s),
    .pop_data    (head_s),
    .count       (count_s)
  );

  // Pop from IDLE as soon as data exists, or at the end of STOP for back-to-back frames.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE:    pop_s = nonempty_s;
      STOP:    pop_s = baud_tc_s & nonempty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Frame sequencer; tx_r is loaded with the level of the state being entered.
  always_ff @(posedge clock_input) begin
    if (reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= 16'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      tx_r       <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          tx_r <= IDLE_LEVEL;
          if (pop_s) begin
            shift_r    <= head_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= even_parity(head_s);
`endif
            baud_cnt_r <= 16'd0;
            state_r    <= START;
            tx_r       <= 1'b0;
          end
        end
        START: begin
          if (baud_tc_s) begin
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            state_r    <= DATA;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (baud_tc_s) begin
            baud_cnt_r <= 16'd0;
            if (bit_idx_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_r <= PARITY;
              tx_r    <= parity_r;
`else
              state_r <= STOP;
              tx_r    <= IDLE_LEVEL;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[bit_idx_r + 3'd1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tc_s) begin
            baud_cnt_r <= 16'd0;
            state_r    <= STOP;
            tx_r       <= IDLE_LEVEL;
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
`endif
        STOP: begin
          if (baud_tc_s) begin
            baud_cnt_r <= 16'd0;
            if (pop_s) begin
              shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
              parity_r <= even_parity(head_s);
`endif
              state_r  <= START;
              tx_r     <= 1'b0;
            end else begin
              state_r  <= IDLE;
              tx_r     <= IDLE_LEVEL;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= 16'd0;
          tx_r       <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign tx         = tx_r;
  assign busy       = (state_r != IDLE) | nonempty_s;
  assign fifo_count = count_s;

endmodule
